load_store_unit: RTL and testbench

- Execute-to-memory stage directly downstream of the address-generation unit; consumes the effective address plus the load/store opcode.
- Drives a word-addressed data-memory port with byte enables and a req/gnt/rvalid handshake.
- Aligns and extends load data for writeback and flags misaligned accesses.
- Stalls the pipeline while a transaction is outstanding; bounds every wait with a timeout counter.

---
 rtl/load_store_unit_pkg.sv | 51 +++++
 rtl/load_store_unit_align.sv | 51 +++++
 rtl/load_store_unit.sv | 162 ++++++++++++++++
 tb/tb_load_store_unit.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : core (package)
// Brief    : Memory opcode / LSU state types and opcode classification helpers.
// Revision : 1.0 - initial release
// ============================================================================
package core;

    typedef enum logic [3:0] {
        MEM_NOP = 4'd0,
        MEM_LB  = 4'd1,
        MEM_LH  = 4'd2,
        MEM_LW  = 4'd3,
        MEM_LBU = 4'd4,
        MEM_LHU = 4'd5,
        MEM_SB  = 4'd6,
        MEM_SH  = 4'd7,
        MEM_SW  = 4'd8
    } mem_op_t;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2
    } lsu_state_t;

    localparam logic [1:0] c_size_byte = 2'd0;
    localparam logic [1:0] c_size_half = 2'd1;
    localparam logic [1:0] c_size_word = 2'd2;

    function automatic logic is_load(input mem_op_t op);
        return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
               (op == MEM_LBU) || (op == MEM_LHU);
    endfunction

    function automatic logic is_store(input mem_op_t op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    // MEM_NOP reports byte size so it can never look misaligned.
    function automatic logic [1:0] op_size(input mem_op_t op);
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: return c_size_half;
            MEM_LW, MEM_SW:          return c_size_word;
            default:                 return c_size_byte;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_align.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Brief    : Combinational byte-enable, store lane shift, load extract and
//            misalignment detection.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_align
    import core::*;
(
    input  mem_op_t     op,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] load_raw,
    output logic [3:0]  be,
    output logic [31:0] store_lane,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [4:0]  w_shift;
    logic [31:0] w_raw;
    logic [1:0]  w_size;

    always_comb begin
        w_shift    = {offset, 3'b000};
        w_size     = op_size(op);
        w_raw      = load_raw >> w_shift;
        store_lane = store_data << w_shift;

        case (w_size)
            c_size_byte: be = 4'b0001 << offset;
            c_size_half: be = 4'b0011 << offset;
            default:     be = 4'b1111;
        endcase

        case (op)
            MEM_LB:  load_data = {{24{w_raw[7]}}, w_raw[7:0]};
            MEM_LH:  load_data = {{16{w_raw[15]}}, w_raw[15:0]};
            MEM_LBU: load_data = {24'd0, w_raw[7:0]};
            MEM_LHU: load_data = {16'd0, w_raw[15:0]};
            default: load_data = w_raw;
        endcase

        misalign = ((w_size == c_size_half) && offset[0]) ||
                   ((w_size == c_size_word) && (offset != 2'b00));
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : Execute-to-memory stage driving a req/gnt/rvalid data port with
//            alignment, load extension and timeout-bounded waits.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit
    import core::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  mem_op_t           mem_op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    input  logic [4:0]        rd_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [3:0]        dmem_be_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [31:0]       dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [31:0]       dmem_rdata_i,
    output logic              wb_valid_o,
    output logic [4:0]        wb_rd_o,
    output logic [31:0]       wb_data_o,
    output logic              stall_o,
    output logic              misalign_o,
    output logic              bus_err_o
);

    localparam int               c_cnt_w   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

    lsu_state_t          r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    mem_op_t             r_op;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [4:0]          r_rd;
    logic                r_wb_valid;
    logic [4:0]          r_wb_rd;
    logic [31:0]         r_wb_data;
    logic                r_misalign;
    logic                r_bus_err;

    logic                w_idle;
    logic                w_req;
    logic                w_accept;
    mem_op_t             w_op;
    logic [1:0]          w_off;
    logic [31:0]         w_sdata;
    logic [3:0]          w_be;
    logic [31:0]         w_lane;
    logic [31:0]         w_load_data;
    logic                w_misalign;

    assign w_idle   = (r_state == LSU_IDLE);
    assign w_req    = (r_state == LSU_REQ);
    assign w_accept = req_valid_i && w_idle && (mem_op_i != MEM_NOP);

    // In IDLE the aligner inspects the incoming request for the misalign
    // check; otherwise it works on the latched transaction.
    assign w_op    = w_idle ? mem_op_i     : r_op;
    assign w_off   = w_idle ? addr_i[1:0]  : r_addr[1:0];
    assign w_sdata = w_idle ? wdata_i      : r_wdata;

    lsu_align u_align (
        .op         (w_op),
        .offset     (w_off),
        .store_data (w_sdata),
        .load_raw   (dmem_rdata_i),
        .be         (w_be),
        .store_lane (w_lane),
        .load_data  (w_load_data),
        .misalign   (w_misalign)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= LSU_IDLE;
            r_cnt      <= '0;
            r_op       <= MEM_NOP;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd       <= '0;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
            case (r_state)
                LSU_IDLE: begin
                    if (w_accept) begin
                        if (w_misalign) begin
                            r_misalign <= 1'b1;
                        end else begin
                            r_op    <= mem_op_i;
                            r_addr  <= addr_i;
                            r_wdata <= wdata_i;
                            r_rd    <= rd_i;
                            r_cnt   <= '0;
                            r_state <= LSU_REQ;
                        end
                    end
                end
                LSU_REQ: begin
                    // A same-cycle rvalid is ignored: data can only follow gnt.
                    if (dmem_gnt_i) begin
                        r_cnt   <= '0;
                        r_state <= is_store(r_op) ? LSU_IDLE : LSU_WAIT;
                    end else if (r_cnt == c_cnt_last) begin
                        r_bus_err <= 1'b1;
                        r_state   <= LSU_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                LSU_WAIT: begin
                    if (dmem_rvalid_i) begin
                        r_wb_valid <= 1'b1;
                        r_wb_rd    <= r_rd;
                        r_wb_data  <= w_load_data;
                        r_state    <= LSU_IDLE;
                    end else if (r_cnt == c_cnt_last) begin
                        r_bus_err <= 1'b1;
                        r_state   <= LSU_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= LSU_IDLE;
            endcase
        end
    end

    assign req_ready_o  = w_idle;
    assign stall_o      = !w_idle;
    assign dmem_req_o   = w_req;
    assign dmem_we_o    = w_req && is_store(r_op);
    assign dmem_be_o    = w_req ? w_be : 4'b0000;
    assign dmem_addr_o  = w_req ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
    assign dmem_wdata_o = w_req ? w_lane : 32'd0;
    assign wb_valid_o   = r_wb_valid;
    assign wb_rd_o      = r_wb_rd;
    assign wb_data_o    = r_wb_data;
    assign misalign_o   = r_misalign;
    assign bus_err_o    = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Randomized scoreboard bench with a behavioural memory-op model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;
    import core::*;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    mem_op_t     mem_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall;
    logic        misalign;
    logic        bus_err;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .mem_op_i(mem_op), .addr_i(addr), .wdata_i(wdata), .rd_i(rd),
        .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_be_o(dmem_be),
        .dmem_addr_o(dmem_addr), .dmem_wdata_o(dmem_wdata),
        .dmem_gnt_i(dmem_gnt), .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata),
        .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
        .stall_o(stall), .misalign_o(misalign), .bus_err_o(bus_err)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    mem_t exp_mem[$];
    wb_t  exp_wb[$];
    int   exp_mis = 0;
    int   exp_err = 0;
    int   compared = 0;
    int   mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic flag(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // ---------------- reference model ----------------
    function automatic int op_bytes(input mem_op_t op);
        if (op == MEM_LB || op == MEM_LBU || op == MEM_SB) return 1;
        if (op == MEM_LH || op == MEM_LHU || op == MEM_SH) return 2;
        return 4;
    endfunction

    function automatic bit op_is_load(input mem_op_t op);
        return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
    endfunction

    function automatic logic [31:0] model_load(input mem_op_t op, input logic [31:0] a,
                                               input logic [31:0] raw);
        logic [31:0] v;
        v = raw >> (8 * (a % 4));
        case (op)
            MEM_LB:  begin v = v % 256;   if (v >= 128)   v = v - 32'd256;   end
            MEM_LH:  begin v = v % 65536; if (v >= 32768) v = v - 32'd65536; end
            MEM_LBU: v = v % 256;
            MEM_LHU: v = v % 65536;
            default: ;
        endcase
        return v;
    endfunction

    // ---------------- monitor ----------------
    logic        prev_hold = 1'b0;
    logic        prev_we;
    logic [31:0] prev_addr;
    logic [3:0]  prev_be;
    logic [31:0] prev_wdata;

    always @(negedge clk) begin
        if (!rst) begin
            if (dmem_req) begin
                check("stall_in_req", {31'd0, stall}, 32'd1);
                if (prev_hold) begin
                    check("hold_addr", dmem_addr, prev_addr);
                    check("hold_be", {28'd0, dmem_be}, {28'd0, prev_be});
                    check("hold_we", {31'd0, dmem_we}, {31'd0, prev_we});
                    check("hold_wdata", dmem_wdata, prev_wdata);
                end
                if (dmem_gnt) begin
                    if (exp_mem.size() == 0) flag("unexpected_mem_req");
                    else begin
                        mem_t e;
                        e = exp_mem.pop_front();
                        check("mem_we", {31'd0, dmem_we}, {31'd0, e.we});
                        check("mem_addr", dmem_addr, e.addr);
                        check("mem_be", {28'd0, dmem_be}, {28'd0, e.be});
                        if (e.we) check("mem_wdata", dmem_wdata, e.wdata);
                    end
                end
            end
            if (wb_valid) begin
                if (exp_wb.size() == 0) flag("unexpected_wb");
                else begin
                    wb_t w;
                    w = exp_wb.pop_front();
                    check("wb_rd", {27'd0, wb_rd}, {27'd0, w.rd});
                    check("wb_data", wb_data, w.data);
                end
            end
            if (misalign) begin
                if (exp_mis == 0) flag("unexpected_misalign");
                else begin
                    exp_mis--;
                    check("misalign_no_req", {31'd0, dmem_req}, 32'd0);
                end
            end
            if (bus_err) begin
                if (exp_err == 0) flag("unexpected_bus_err");
                else begin
                    exp_err--;
                    check("buserr_req_drop", {31'd0, dmem_req}, 32'd0);
                    check("buserr_ready", {31'd0, req_ready}, 32'd1);
                end
            end
        end
        prev_hold  <= dmem_req && !dmem_gnt && !rst;
        prev_we    <= dmem_we;
        prev_addr  <= dmem_addr;
        prev_be    <= dmem_be;
        prev_wdata <= dmem_wdata;
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
        dmem_rdata = $urandom;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 100) begin step(); n++; end
        if (n == 100) flag("ready_timeout");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        check({tag, "_outs"}, {27'd0, dmem_req, dmem_we, wb_valid, stall, misalign}, 32'd0);
        check({tag, "_bus_err"}, {31'd0, bus_err}, 32'd0);
        check({tag, "_be"}, {28'd0, dmem_be}, 32'd0);
        check({tag, "_addr"}, dmem_addr, 32'd0);
        check({tag, "_wdata"}, dmem_wdata, 32'd0);
        check({tag, "_wb"}, {wb_rd, wb_data[26:0]} | {27'd0, wb_data[31:27]}, 32'd0);
    endtask

    task automatic issue(input mem_op_t op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] r, input logic [31:0] rdata,
                         input int gnt_dly, input int rv_dly, input bit dual);
        bit ld;
        bit mis;
        mem_t e;
        ld  = op_is_load(op);
        mis = (a % op_bytes(op)) != 0;
        wait_ready();
        req_valid = 1'b1; mem_op = op; addr = a; wdata = wd; rd = r;
        if (mis) exp_mis++;
        else begin
            e.we    = !ld;
            e.addr  = a - (a % 4);
            e.be    = 4'(((1 << op_bytes(op)) - 1) << (a % 4));
            e.wdata = wd << (8 * (a % 4));
            if (gnt_dly < TO) exp_mem.push_back(e);
            if (gnt_dly >= TO || (ld && rv_dly >= TO)) exp_err++;
            else if (ld) exp_wb.push_back('{rd: r, data: model_load(op, a, rdata)});
        end
        step();
        req_valid = 1'b0; mem_op = MEM_NOP; addr = $urandom; wdata = $urandom; rd = 5'($urandom);
        if (mis) begin
            check("mis_ready", {31'd0, req_ready}, 32'd1);
            step();
            return;
        end
        for (int i = 0; i < gnt_dly && i < TO; i++) step();
        if (gnt_dly >= TO) return;
        dmem_gnt = 1'b1;
        dmem_rvalid = dual;
        step();
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b0;
        if (!ld) begin
            check("store_ready_after_gnt", {31'd0, req_ready}, 32'd1);
            return;
        end
        for (int i = 0; i < rv_dly && i < TO; i++) step();
        if (rv_dly >= TO) return;
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        @(posedge clk);
        #1;
        dmem_rvalid = 1'b0;
        dmem_rdata  = $urandom;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; mem_op = MEM_NOP; addr = '0; wdata = '0; rd = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("reset");

        // directed cases
        issue(MEM_SW,  32'h100, 32'hDEADBEEF, 5'd1,  32'h0, 0, 0, 0);
        issue(MEM_LB,  32'h203, 32'h0, 5'd7,  32'h80123456, 0, 0, 0);
        issue(MEM_LBU, 32'h203, 32'h0, 5'd8,  32'h80123456, 0, 0, 0);
        issue(MEM_SH,  32'h102, 32'h0000ABCD, 5'd2, 32'h0, 5, 0, 0);
        issue(MEM_LW,  32'h101, 32'h0, 5'd3,  32'h0, 0, 0, 0);
        issue(MEM_LW,  32'h300, 32'h0, 5'd4,  32'h0, TO, 0, 0);
        issue(MEM_LH,  32'h402, 32'h0, 5'd5,  32'h8001FFFF, TO - 1, TO - 1, 0);
        issue(MEM_LHU, 32'h406, 32'h0, 5'd6,  32'h8001FFFF, 1, TO, 0);
        issue(MEM_LW,  32'h408, 32'h0, 5'd9,  32'hCAFEF00D, 0, 1, 1);

        // reset while waiting for read data; late rvalid/gnt must be ignored
        wait_ready();
        req_valid = 1'b1; mem_op = MEM_LW; addr = 32'h500; rd = 5'd10;
        exp_mem.push_back('{we: 1'b0, addr: 32'h500, be: 4'hF, wdata: 32'h0});
        step();
        req_valid = 1'b0; mem_op = MEM_NOP;
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs("rst_wait");
        dmem_rvalid = 1'b1; dmem_gnt = 1'b1;
        step();
        dmem_rvalid = 1'b0; dmem_gnt = 1'b0;
        repeat (3) step();

        // randomized traffic with interleaved NOP requests
        for (int n = 0; n < 250; n++) begin
            mem_op_t op;
            int gd;
            int rv;
            op = mem_op_t'(4'($urandom_range(1, 8)));
            gd = ($urandom_range(0, 19) == 0) ? $urandom_range(TO - 1, TO) : $urandom_range(0, 3);
            rv = ($urandom_range(0, 19) == 0) ? $urandom_range(TO - 1, TO) : $urandom_range(0, 3);
            issue(op, {20'd0, 12'($urandom)}, $urandom, 5'($urandom), $urandom, gd, rv,
                  $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) begin
                req_valid = 1'b1; mem_op = MEM_NOP; addr = $urandom;
                step();
                req_valid = 1'b0;
                check("nop_ready", {31'd0, req_ready}, 32'd1);
            end
        end

        repeat (5) step();
        check("leftover_mem", exp_mem.size(), 32'd0);
        check("leftover_wb", exp_wb.size(), 32'd0);
        check("leftover_mis", exp_mis, 32'd0);
        check("leftover_err", exp_err, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
